// File: rtl/led_pwm_ctrl_pkg.sv
// led_pwm_ctrl_pkg
// Shared definitions for the LED PWM controller:
//   - register word addresses (bus addr = CPU Addr[3:2])
//   - merge_bytes(): combines a write word into an existing word under byte enables
`timescale 1ns/1ps

package led_pwm_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MODE   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_DUTY   = 2'd3;

    // Lane i of the result comes from new_word when be[i] is set, else from old_word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/led_pwm_timer.sv
// led_pwm_timer
// Blink prescaler and PWM counter for the LED controller.
//   clk, reset       : clock, synchronous active-high reset
//   i_period         : blink half-period minus one (bcnt wrap value)
//   i_duty           : PWM duty; all-ones = always on, 0 = always off
//   i_clr_bcnt       : restart the blink prescaler (phase is held)
//   o_blink_phase    : blink phase, 1 after reset
//   o_pwm_on         : PWM gate for the current cycle (combinational)
`timescale 1ns/1ps

module led_pwm_timer
    import led_pwm_ctrl_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_period,
    input  logic [PWM_W-1:0] i_duty,
    input  logic             i_clr_bcnt,
    output logic             o_blink_phase,
    output logic             o_pwm_on
);

    logic [CNT_W-1:0] r_bcnt;
    logic             r_blink_phase;
    logic [PWM_W-1:0] r_pcnt;
    logic             w_pwm_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt        <= '0;
            r_blink_phase <= 1'b1;
            r_pcnt        <= '0;
        end else begin
            r_pcnt <= r_pcnt + PWM_W'(1);
            // A PERIOD rewrite restarts the count so a smaller new PERIOD
            // never has to wait for bcnt to roll over the whole counter range.
            // The phase deliberately does not toggle on that edge.
            if (i_clr_bcnt) begin
                r_bcnt <= '0;
            end else if (r_bcnt == i_period) begin
                r_bcnt        <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_bcnt <= r_bcnt + CNT_W'(1);
            end
        end
    end

    // All-ones duty must be fully on; pcnt < duty alone would drop the last count.
    always_comb begin
        w_pwm_on = 1'b0;
        if (i_duty == '1) begin
            w_pwm_on = 1'b1;
        end else if (i_duty == '0) begin
            w_pwm_on = 1'b0;
        end else begin
            w_pwm_on = (r_pcnt < i_duty);
        end
    end

    assign o_blink_phase = r_blink_phase;
    assign o_pwm_on      = w_pwm_on;

endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl
// Bus-mapped LED output controller with per-bit blink and global PWM dimming.
//   clk, reset : clock, synchronous active-high reset
//   addr       : register select (0 DATA, 1 MODE, 2 PERIOD, 3 DUTY)
//   we, be, din: single-cycle write with byte enables
//   dout       : combinational, zero-extended read of the selected register
//   led_light  : registered LED drive, 1 = lit
`timescale 1ns/1ps

module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          CNT_W      = 24,
    parameter int          PWM_W      = 8,
    parameter logic [31:0] PERIOD_RST = 32'd4999999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic [WIDTH-1:0] led_light
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mode;
    logic [CNT_W-1:0] r_period;
    logic [PWM_W-1:0] r_duty;
    logic [WIDTH-1:0] r_led;

    logic             w_wr_hit;
    logic             w_clr_bcnt;
    logic [31:0]      w_merged;
    logic [31:0]      w_rdata;
    logic             w_blink_phase;
    logic             w_pwm_on;
    logic [WIDTH-1:0] w_led_next;

    // Read mux; also supplies the old value for byte-lane merging.
    always_comb begin
        w_rdata = '0;
        case (addr)
            ADDR_DATA:   w_rdata = 32'(r_data);
            ADDR_MODE:   w_rdata = 32'(r_mode);
            ADDR_PERIOD: w_rdata = 32'(r_period);
            ADDR_DUTY:   w_rdata = 32'(r_duty);
            default:     w_rdata = '0;
        endcase
    end

    assign dout = w_rdata;

    // A write with no byte lanes enabled is a complete no-op.
    assign w_wr_hit   = we && (be != 4'b0000);
    assign w_clr_bcnt = w_wr_hit && (addr == ADDR_PERIOD);
    assign w_merged   = merge_bytes(w_rdata, din, be);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= '0;
            r_mode   <= '0;
            r_period <= PERIOD_RST[CNT_W-1:0];
            r_duty   <= '1;
        end else if (w_wr_hit) begin
            case (addr)
                ADDR_DATA:   r_data   <= w_merged[WIDTH-1:0];
                ADDR_MODE:   r_mode   <= w_merged[WIDTH-1:0];
                ADDR_PERIOD: r_period <= w_merged[CNT_W-1:0];
                ADDR_DUTY:   r_duty   <= w_merged[PWM_W-1:0];
                default:     ;
            endcase
        end
    end

    led_pwm_timer #(
        .CNT_W (CNT_W),
        .PWM_W (PWM_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .i_period      (r_period),
        .i_duty        (r_duty),
        .i_clr_bcnt    (w_clr_bcnt),
        .o_blink_phase (w_blink_phase),
        .o_pwm_on      (w_pwm_on)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_led
            assign w_led_next[gi] = r_data[gi]
                                  & (r_mode[gi] ? w_blink_phase : 1'b1)
                                  & w_pwm_on;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign led_light = r_led;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
`timescale 1ns/1ps

module tb_led_pwm_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] led_light;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    localparam logic [31:0] PERIOD_RST_VAL = 32'd4999999;

    led_pwm_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .we        (we),
        .be        (be),
        .din       (din),
        .dout      (dout),
        .led_light (led_light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a;
        din  = d;
        be   = b;
        we   = 1'b1;
        cycle();
        we   = 1'b0;
        be   = 4'h0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        we    = 1'b1;
        addr  = 2'd0;
        din   = 32'hFFFF_FFFF;
        be    = 4'hF;
        cycle();
        cycle();
        we    = 1'b0;
        be    = 4'h0;
        reset = 1'b0;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (led_light !== e) begin
            n_fail++;
            $display("FAIL reset_led: got %h expected %h", led_light, e);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(PERIOD_RST_VAL & 32'h00FF_FFFF);
        exp_q.push_back(32'h0000_00FF);
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (dout !== e) begin
                n_fail++;
                $display("FAIL reset_read addr%0d: got %h expected %h", i, dout, e);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_static();
        wr(2'd0, 32'h0000_00A5, 4'hF);
        addr = 2'd0;
        #1;
        exp_q.push_back(32'h0000_00A5);
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e) begin
            n_fail++;
            $display("FAIL static_read: got %h expected %h", dout, e);
        end
        // Output lags the register by one edge.
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (led_light !== e) begin
            n_fail++;
            $display("FAIL static_led_latency: got %h expected %h", led_light, e);
        end
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(32'h0000_00A5);
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (led_light !== e) begin
                n_fail++;
                $display("FAIL static_led k=%0d: got %h expected %h", k, led_light, e);
            end
        end
        $display("test_static done");
    endtask

    task automatic test_byte_en();
        wr(2'd0, 32'h0, 4'hF);
        wr(2'd0, 32'hFFFF_FFFF, 4'b0010);
        addr = 2'd0;
        #1;
        exp_q.push_back(32'h0000_FF00);
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e) begin
            n_fail++;
            $display("FAIL byte_en_lane1: got %h expected %h", dout, e);
        end
        wr(2'd0, 32'h1234_5678, 4'h0);
        addr = 2'd0;
        #1;
        exp_q.push_back(32'h0000_FF00);
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e) begin
            n_fail++;
            $display("FAIL byte_en_none: got %h expected %h", dout, e);
        end
        // Lane 3 lies above the 24-bit PERIOD register and must be ignored.
        wr(2'd2, 32'hFFFF_FFFF, 4'b1000);
        addr = 2'd2;
        #1;
        exp_q.push_back(PERIOD_RST_VAL & 32'h00FF_FFFF);
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e) begin
            n_fail++;
            $display("FAIL byte_en_period_top: got %h expected %h", dout, e);
        end
        $display("test_byte_en done");
    endtask

    task automatic test_blink();
        logic b0;
        apply_reset();
        wr(2'd1, 32'h1, 4'hF);
        wr(2'd0, 32'h3, 4'hF);
        wr(2'd2, 32'd3, 4'hF);      // bcnt restarts here, phase 1
        // LED after edge j (j edges past the PERIOD write): 4 high, 4 low, ...
        for (int j = 1; j <= 18; j++) begin
            b0 = (((j - 1) / 4) % 2) == 0;
            exp_q.push_back({30'h0, 1'b1, b0});
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (led_light !== e) begin
                n_fail++;
                $display("FAIL blink j=%0d: got %h expected %h", j, led_light, e);
            end
        end
        // Rewrite PERIOD with bcnt = 2 mid-phase: phase must end 2 edges later.
        exp_q.push_back(32'h3);
        wr(2'd2, 32'd1, 4'hF);
        e = exp_q.pop_front();
        n_checks++;
        if (led_light !== e) begin
            n_fail++;
            $display("FAIL blink_rewrite k=0: got %h expected %h", led_light, e);
        end
        for (int k = 1; k <= 8; k++) begin
            b0 = (((k - 1) / 2) % 2) == 0;
            exp_q.push_back({30'h0, 1'b1, b0});
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (led_light !== e) begin
                n_fail++;
                $display("FAIL blink_rewrite k=%0d: got %h expected %h", k, led_light, e);
            end
        end
        $display("test_blink done");
    endtask

    task automatic test_pwm();
        int highs;
        apply_reset();
        wr(2'd0, 32'h1, 4'hF);      // edge n=1, pcnt=1
        wr(2'd3, 32'h40, 4'hF);     // edge n=2
        highs = 0;
        for (int n = 3; n <= 514; n++) begin
            exp_q.push_back((((n - 1) % 256) < 64) ? 32'h1 : 32'h0);
            cycle();
            if (n <= 258 && led_light[0] === 1'b1) highs++;
            e = exp_q.pop_front();
            n_checks++;
            if (led_light !== e) begin
                n_fail++;
                $display("FAIL pwm_40 n=%0d: got %h expected %h", n, led_light, e);
            end
        end
        n_checks++;
        if (highs !== 64) begin
            n_fail++;
            $display("FAIL pwm_40_count: got %0d expected 64", highs);
        end
        wr(2'd3, 32'h0, 4'hF);
        for (int n = 0; n < 256; n++) begin
            exp_q.push_back(32'h0);
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (led_light !== e) begin
                n_fail++;
                $display("FAIL pwm_00 n=%0d: got %h expected %h", n, led_light, e);
            end
        end
        wr(2'd3, 32'hFF, 4'hF);
        for (int n = 0; n < 256; n++) begin
            exp_q.push_back(32'h1);
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (led_light !== e) begin
                n_fail++;
                $display("FAIL pwm_ff n=%0d: got %h expected %h", n, led_light, e);
            end
        end
        $display("test_pwm done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        wr(2'd1, 32'h1, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        wr(2'd2, 32'd3, 4'hF);
        for (int k = 0; k < 5; k++) cycle();
        exp_q.push_back(32'h0);     // phase 0 now
        e = exp_q.pop_front();
        n_checks++;
        if (led_light !== e) begin
            n_fail++;
            $display("FAIL reset_mid_phase0: got %h expected %h", led_light, e);
        end
        reset = 1'b1;
        we    = 1'b1;
        addr  = 2'd0;
        din   = 32'h0000_00FF;
        be    = 4'hF;
        cycle();
        we    = 1'b0;
        be    = 4'h0;
        reset = 1'b0;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (led_light !== e) begin
            n_fail++;
            $display("FAIL reset_mid_led: got %h expected %h", led_light, e);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(PERIOD_RST_VAL & 32'h00FF_FFFF);
        exp_q.push_back(32'h0000_00FF);
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (dout !== e) begin
                n_fail++;
                $display("FAIL reset_mid_read addr%0d: got %h expected %h", i, dout, e);
            end
        end
        wr(2'd1, 32'h1, 4'hF);
        exp_q.push_back(32'h0);
        wr(2'd0, 32'h1, 4'hF);
        e = exp_q.pop_front();
        n_checks++;
        if (led_light !== e) begin
            n_fail++;
            $display("FAIL reset_mid_restart0: got %h expected %h", led_light, e);
        end
        exp_q.push_back(32'h1);
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (led_light !== e) begin
            n_fail++;
            $display("FAIL reset_mid_restart1: got %h expected %h", led_light, e);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        we       = 1'b0;
        be       = 4'h0;
        addr     = 2'd0;
        din      = 32'h0;
        test_reset();
        test_static();
        test_byte_en();
        test_blink();
        test_pwm();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Bus-mapped LED output controller. Parametrised successor to the plain LED latch peripheral on the CPU bridge.
- Holds WIDTH LED outputs. Each bit is either static or blinking.
- One global PWM brightness duty applies to all bits.
- Software can read back every register. Byte-enable writes are supported.

Parameters:
- WIDTH, 32, number of LED outputs (1..32).
- CNT_W, 24, blink prescaler counter width (1..32).
- PWM_W, 8, PWM counter and duty width (1..16).
- PERIOD_RST, 24'd4999999, reset value of PERIOD (truncated to CNT_W).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  word select (CPU Addr[3:2]).
- we  in  1  write strobe, sampled at posedge clk.
- be  in  4  byte enables for din; be[i] gates din[8i+7:8i].
- din  in  32  write data.
- dout  out  32  combinational read data for addr, zero-extended.
- led_light  out  WIDTH  registered LED drive, 1 = lit.

Behaviour:
- Register map (addr):
  - 0 DATA[WIDTH-1:0], reset 0.
  - 1 MODE[WIDTH-1:0], bit = 1 means blink; reset 0.
  - 2 PERIOD[CNT_W-1:0], reset PERIOD_RST.
  - 3 DUTY[PWM_W-1:0], reset all-ones.
- Writes: when we = 1 at posedge, each byte lane with be set updates the selected register. Register bits above the register width are ignored; unselected lanes keep their value.
- Reads: dout = selected register, zero-extended. Pure combinational, no side effects. Reflects the new value in the cycle after the write edge.
- Blink timer:
  - bcnt (CNT_W) increments each cycle.
  - When bcnt == PERIOD: bcnt goes to 0 and blink_phase toggles.
  - Half-period is therefore PERIOD+1 cycles. PERIOD = 0 toggles every cycle.
  - blink_phase resets to 1.
- Any write hitting addr 2 (any be bit set) clears bcnt to 0 on that edge. blink_phase is not toggled by the write, even if a wrap coincides. This avoids an overshoot when the new PERIOD is smaller than bcnt.
- PWM:
  - pcnt (PWM_W) free-runs 0..2^PWM_W-1 and wraps; resets to 0.
  - pwm_on = 1 when DUTY is all-ones; 0 when DUTY = 0; otherwise (pcnt < DUTY).
- Output: each posedge, led_light[i] <= DATA[i] & (MODE[i] ? blink_phase : 1) & pwm_on. The expression uses current-cycle register and counter values.
- Latency: a write at edge k changes the register at k. led_light reflects it at edge k+1.
- Reset:
  - All registers, counters and blink_phase take their reset values, and led_light = 0.
  - Reset wins over a simultaneous we.
  - Reset mid-blink restarts phase 1 with bcnt = 0.
- we with be = 0 is a no-op, including no bcnt clear.
- Simultaneous write and counter wrap both take effect, except the addr-2 rule above.
- No other state. No bus handshake; every access completes in one cycle.

Decomposition:
- Shared package holds:
  - Register address constants ADDR_DATA = 0, ADDR_MODE = 1, ADDR_PERIOD = 2, ADDR_DUTY = 3.
  - A byte-lane merge function: old, new, be -> merged word.
- One sub-module: led_pwm_timer. It contains bcnt/blink_phase and pcnt/pwm_on, with inputs PERIOD, DUTY and clr_bcnt.
- The top level keeps the register file, read mux and output register.

Test Plan:
- Reset values: assert reset 2 cycles → led_light = 0. Reads give DATA = 0, MODE = 0, PERIOD = PERIOD_RST, DUTY = 0xFF.
- Static write: DATA = 0x000000A5 with be = 4'hF (DUTY = 0xFF, MODE = 0) → dout(addr 0) = 0xA5 next cycle; led_light = 0xA5 one edge after the write edge, held steady.
- Byte enables: DATA = 0, then write 0xFFFFFFFF with be = 4'b0010 → DATA = 0x0000FF00. A write with be = 0 leaves it unchanged.
- Blink: PERIOD = 3, MODE = 0x1, DATA = 0x3 → bit1 constant 1. Bit0 alternates 4 cycles high / 4 low starting high. Rewrite PERIOD = 1 mid-phase → the current phase ends 2 cycles after the write edge.
- PWM: DUTY = 0x40, DATA = 0x1, MODE = 0 → bit0 high exactly 64 of every 256 cycles, contiguous from pcnt = 0. DUTY = 0 → bit0 always 0.
- Reset mid-operation: blinking with phase 0, assert reset together with we to DATA → write discarded, all reset values, led_light = 0. After release with DATA = 0x1, MODE = 0x1, bit0 starts lit.
